float_exp2_pipe: RTL

- Parametrised, fully pipelined floating-point 2^x unit. Optional e^x mode.
- Successor to the fixed-format half-precision exp2 chain; self-contained, with no half_add or half_multiply sub-instances.
- Adds valid/ready backpressure, a sideband tag, IEEE special-case handling and overflow/underflow saturation.
- Feeds softmax and activation stages in the network datapath.

---
 rtl/float_exp2_pipe.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/float_exp2_pipe.sv
// Five-stage pipelined 2^x (optionally e^x) unit for a parametrised IEEE-like float.
// The fraction power uses a linearly interpolated table; specials bypass the datapath.
module float_exp2_pipe #(
    parameter int EXP_W    = 5,
    parameter int MAN_W    = 10,
    parameter int MODE_E   = 0,
    parameter int LUT_BITS = 6,
    parameter int TAG_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] c,
    output logic [TAG_W-1:0]     out_tag,
    output logic [2:0]           out_flags
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int FRAC  = MAN_W + 3;
    localparam int GR    = FRAC - MAN_W;
    localparam int SIG_W = FRAC + 1;
    localparam int FX_W  = EXP_W + 1 + FRAC;
    localparam int UE_W  = EXP_W + 2;
    localparam int R_W   = FRAC - LUT_BITS;
    localparam int TW    = FRAC + 2;
    localparam int LUT_N = 1 << LUT_BITS;
    localparam int EX_W  = EXP_W + 3;
    localparam int P_W   = 2 * MAN_W + 5;

    localparam logic [W-1:0] INF  = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0] ONE  = {2'b00, {(EXP_W-1){1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-1:0] ZERO = '0;
    localparam logic [SIG_W-1:0] LOG2E =
        SIG_W'($rtoi(1.4426950408889634 * (2.0 ** FRAC) + 0.5));

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // S1: unpack, optional log2(e) prescale, resolve special operands
    logic             a_sign;
    logic [EXP_W-1:0] a_exp;
    logic [MAN_W-1:0] a_man;
    logic [P_W-1:0]   e_prod;
    logic [SIG_W-1:0] sig_c;
    logic [UE_W-1:0]  ue_c;
    logic             frc_c;
    logic [W-1:0]     fc_c;
    logic [2:0]       ff_c;

    assign {a_sign, a_exp, a_man} = a;
    assign e_prod = P_W'({1'b1, a_man}) * P_W'(LOG2E);

    always_comb begin
        sig_c = {1'b1, a_man, {GR{1'b0}}};
        ue_c  = UE_W'(a_exp) - UE_W'(BIAS);
        frc_c = 1'b1;
        fc_c  = ZERO;
        ff_c  = 3'b000;
        if (MODE_E != 0) begin
            if (e_prod[P_W-1]) begin
                sig_c = SIG_W'(e_prod >> (MAN_W + 1));
                ue_c  = ue_c + UE_W'(1);
            end else begin
                sig_c = SIG_W'(e_prod >> MAN_W);
            end
        end
        if (a_exp == '1) begin
            if (a_man != '0) begin
                fc_c = QNAN;
                ff_c = 3'b100;
            end else if (!a_sign) begin
                fc_c = INF;
            end
        end else if (a_exp == '0) begin
            fc_c = ONE;
        end else begin
            frc_c = 1'b0;
        end
    end

    logic             s1_v, s1_sign, s1_frc;
    logic [TAG_W-1:0] s1_tag;
    logic [UE_W-1:0]  s1_ue;
    logic [SIG_W-1:0] s1_sig;
    logic [W-1:0]     s1_fc;
    logic [2:0]       s1_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
        end else if (adv) begin
            s1_v    <= in_valid;
            s1_tag  <= in_tag;
            s1_sign <= a_sign;
            s1_ue   <= ue_c;
            s1_sig  <= sig_c;
            s1_frc  <= frc_c;
            s1_fc   <= fc_c;
            s1_ff   <= ff_c;
        end
    end

    // S2: signed fixed point; magnitudes of 2^(EXP_W-1) or more saturate
    logic [UE_W-1:0] rsh;
    logic [FX_W-1:0] mag, x_c;
    logic            big;

    assign rsh = -s1_ue;
    assign big = !s1_ue[UE_W-1] && (s1_ue >= UE_W'(EXP_W - 1));
    assign mag = s1_ue[UE_W-1] ? (FX_W'(s1_sig) >> rsh) : (FX_W'(s1_sig) << s1_ue);
    assign x_c = s1_sign ? -mag : mag;

    logic             s2_v, s2_frc;
    logic [TAG_W-1:0] s2_tag;
    logic [FX_W-1:0]  s2_x;
    logic [W-1:0]     s2_fc;
    logic [2:0]       s2_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v <= 1'b0;
        end else if (adv) begin
            s2_v   <= s1_v;
            s2_tag <= s1_tag;
            s2_x   <= x_c;
            s2_frc <= s1_frc | big;
            if (s1_frc) begin
                s2_fc <= s1_fc;
                s2_ff <= s1_ff;
            end else if (s1_sign) begin
                s2_fc <= ZERO;
                s2_ff <= 3'b001;
            end else begin
                s2_fc <= INF;
                s2_ff <= 3'b010;
            end
        end
    end

    // S3: two's complement upper bits are already floor(x)
    logic             s3_v, s3_frc;
    logic [TAG_W-1:0] s3_tag;
    logic [EXP_W:0]   s3_n;
    logic [FRAC-1:0]  s3_f;
    logic [W-1:0]     s3_fc;
    logic [2:0]       s3_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_v <= 1'b0;
        end else if (adv) begin
            s3_v   <= s2_v;
            s3_tag <= s2_tag;
            s3_n   <= s2_x[FX_W-1:FRAC];
            s3_f   <= s2_x[FRAC-1:0];
            s3_frc <= s2_frc;
            s3_fc  <= s2_fc;
            s3_ff  <= s2_ff;
        end
    end

    // S4: 2^f by table lookup plus linear interpolation on the low bits
    logic [TW-1:0] lut [0:LUT_N];
    for (genvar i = 0; i <= LUT_N; i++) begin : g_lut
        localparam real PV = 2.0 ** (real'(i) / real'(LUT_N));
        assign lut[i] = TW'($rtoi(PV * (2.0 ** FRAC) + 0.5));
    end

    logic [LUT_BITS-1:0] k;
    logic [R_W-1:0]      r;
    logic [LUT_BITS:0]   k_lo, k_hi;
    logic [TW-1:0]       t_lo, t_hi;
    logic [TW+R_W-1:0]   t_prod;

    assign {k, r}  = s3_f;
    assign k_lo    = {1'b0, k};
    assign k_hi    = k_lo + (LUT_BITS+1)'(1);
    assign t_lo    = lut[k_lo];
    assign t_hi    = lut[k_hi];
    assign t_prod  = (TW+R_W)'(t_hi - t_lo) * (TW+R_W)'(r);

    logic             s4_v, s4_frc;
    logic [TAG_W-1:0] s4_tag;
    logic [EXP_W:0]   s4_n;
    logic [FRAC-1:0]  s4_y;
    logic [W-1:0]     s4_fc;
    logic [2:0]       s4_ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            s4_v <= 1'b0;
        end else if (adv) begin
            s4_v   <= s3_v;
            s4_tag <= s3_tag;
            s4_n   <= s3_n;
            s4_y   <= FRAC'(t_lo + TW'(t_prod >> R_W));
            s4_frc <= s3_frc;
            s4_fc  <= s3_fc;
            s4_ff  <= s3_ff;
        end
    end

    // S5: round to nearest-even, rebias, saturate the exponent range
    logic             rnd;
    logic [MAN_W:0]   man_r;
    logic [EX_W-1:0]  ex;
    logic [W-1:0]     c_nx;
    logic [2:0]       f_nx;

    assign rnd   = s4_y[GR-1] & ((|s4_y[GR-2:0]) | s4_y[GR]);
    assign man_r = {1'b0, s4_y[FRAC-1:GR]} + (MAN_W+1)'(rnd);
    assign ex    = {{2{s4_n[EXP_W]}}, s4_n} + EX_W'(BIAS) + EX_W'(man_r[MAN_W]);

    always_comb begin
        c_nx = {1'b0, ex[EXP_W-1:0], man_r[MAN_W-1:0]};
        f_nx = 3'b000;
        if (s4_frc) begin
            c_nx = s4_fc;
            f_nx = s4_ff;
        end else if (ex[EX_W-1] || ex == '0) begin
            c_nx = ZERO;
            f_nx = 3'b001;
        end else if (ex >= EX_W'((1 << EXP_W) - 1)) begin
            c_nx = INF;
            f_nx = 3'b010;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            c         <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (adv) begin
            out_valid <= s4_v;
            if (s4_v) begin
                c         <= c_nx;
                out_tag   <= s4_tag;
                out_flags <= f_nx;
            end
        end
    end

endmodule
